// File: rtl/nx_indirect_mem_responder.sv
// Memory-side responder for the indirect-access software port: flop-array table with CAM search,
// arbitrating one access slot per cycle between the functional port and the software port.
// Optional build macro NX_IA_MEM_PARITY_EN adds a stored even-parity bit per entry and par_err.
module nx_indirect_mem_responder #(
    parameter int N_DATA_BITS  = 64,
    parameter int N_ENTRIES    = 16,
    parameter int N_ADDR_BITS  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_cs,
    input  logic                   sw_ce,
    input  logic                   sw_we,
    input  logic [4:0]             sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    input  logic                   yield,
    output logic                   grant,
    output logic [N_DATA_BITS-1:0] sw_rdat,
    output logic                   sw_match,
    output logic [3:0]             sw_aindex,
    input  logic                   fn_rd,
    input  logic                   fn_wr,
    input  logic [N_ADDR_BITS-1:0] fn_addr,
    input  logic [N_DATA_BITS-1:0] fn_wdat,
    output logic                   fn_stall,
    output logic                   fn_rvld,
    output logic [N_DATA_BITS-1:0] fn_rdat,
    output logic                   par_err
);

    localparam int              CW          = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0]   STARVE_MAX  = CW'(STARVE_LIMIT - 1);
    localparam logic [5:0]      ENTRIES_LIM = 6'(N_ENTRIES);

    logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
    logic [CW-1:0]          starve_q, starve_d;
    logic                   fn_req, sw_win, fn_svc;
    logic                   sw_in_range;
    logic [N_ADDR_BITS-1:0] sw_idx;
    logic                   sw_wr, sw_cmp, sw_rd, fn_wr_en, fn_rd_en;

    logic [N_ENTRIES-1:0]   match_vec_d, match_vec_q;
    logic                   cmp_vld_p0_q;
    logic                   hit_d;
    logic [3:0]             aidx_d;
    logic                   sw_match_q;
    logic [3:0]             sw_aindex_q;
    logic [N_DATA_BITS-1:0] sw_rdat_q, fn_rdat_q;
    logic                   fn_rvld_q;

    assign fn_req      = fn_rd | fn_wr;
    assign sw_win      = sw_cs & (~fn_req | yield | (starve_q == STARVE_MAX));
    assign fn_svc      = fn_req & ~sw_win;
    assign grant       = sw_win;
    assign fn_stall    = sw_win & fn_req;

    // Anything at or above N_ENTRIES (including the reserved MSB) is granted but inert.
    assign sw_in_range = ({1'b0, sw_add} < ENTRIES_LIM);
    assign sw_idx      = sw_add[N_ADDR_BITS-1:0];
    assign sw_wr       = sw_win & sw_we;
    assign sw_cmp      = sw_win & ~sw_we & sw_ce;
    assign sw_rd       = sw_win & ~sw_we & ~sw_ce;
    assign fn_wr_en    = fn_svc & fn_wr;
    assign fn_rd_en    = fn_svc & fn_rd & ~fn_wr;

    always_comb begin
        starve_d = starve_q;
        if (!sw_cs || sw_win) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sw_wr && sw_in_range) begin
            mem_q[sw_idx] <= sw_wdat;
        end else if (fn_wr_en) begin
            mem_q[fn_addr] <= fn_wdat;
        end
    end

    // Reads sample the table before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rdat_q <= '0;
            fn_rvld_q <= 1'b0;
            fn_rdat_q <= '0;
        end else begin
            if (sw_rd) begin
                sw_rdat_q <= sw_in_range ? mem_q[sw_idx] : '0;
            end
            fn_rvld_q <= fn_rd_en;
            if (fn_rd_en) begin
                fn_rdat_q <= mem_q[fn_addr];
            end
        end
    end

    always_comb begin
        match_vec_d = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            match_vec_d[i] = (mem_q[i] == sw_wdat);
        end
    end

    // Scanning downward leaves the lowest set index as the final assignment.
    always_comb begin
        hit_d  = 1'b0;
        aidx_d = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec_q[i]) begin
                hit_d  = 1'b1;
                aidx_d = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vec_q  <= '0;
            cmp_vld_p0_q <= 1'b0;
            sw_match_q   <= 1'b0;
            sw_aindex_q  <= '0;
        end else begin
            cmp_vld_p0_q <= sw_cmp;
            if (sw_cmp) begin
                match_vec_q <= match_vec_d;
            end
            if (cmp_vld_p0_q) begin
                sw_match_q  <= hit_d;
                sw_aindex_q <= aidx_d;
            end
        end
    end

    assign sw_rdat   = sw_rdat_q;
    assign sw_match  = sw_match_q;
    assign sw_aindex = sw_aindex_q;
    assign fn_rvld   = fn_rvld_q;
    assign fn_rdat   = fn_rdat_q;

`ifdef NX_IA_MEM_PARITY_EN
    logic par_q [N_ENTRIES];
    logic sw_rpar_q, fn_rpar_q, sw_rvld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                par_q[i] <= 1'b0;
            end
            sw_rpar_q <= 1'b0;
            fn_rpar_q <= 1'b0;
            sw_rvld_q <= 1'b0;
        end else begin
            if (sw_wr && sw_in_range) begin
                par_q[sw_idx] <= ^sw_wdat;
            end else if (fn_wr_en) begin
                par_q[fn_addr] <= ^fn_wdat;
            end
            sw_rvld_q <= sw_rd;
            if (sw_rd) begin
                sw_rpar_q <= sw_in_range ? par_q[sw_idx] : 1'b0;
            end
            if (fn_rd_en) begin
                fn_rpar_q <= par_q[fn_addr];
            end
        end
    end

    assign par_err = (sw_rvld_q & (^sw_rdat_q ^ sw_rpar_q)) |
                     (fn_rvld_q & (^fn_rdat_q ^ fn_rpar_q));
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: doc/nx_indirect_mem_responder.md
Name: nx_indirect_mem_responder

Overview:
- Memory-side responder for the indirect-access controller's software port (sw_cs/sw_ce/sw_we/sw_add/sw_wdat in; grant, sw_rdat, sw_match, sw_aindex out).
- Owns a flop-array table of N_ENTRIES x N_DATA_BITS with a compare (CAM search) function.
- Arbitrates each cycle's single access slot between the functional datapath port and the software port. Functional access has priority, subject to yield and starvation rules.

Parameters:
- N_DATA_BITS, 64, entry width.
- N_ENTRIES, 16, table depth; must be a power of 2, maximum 16.
- N_ADDR_BITS, 4, $clog2(N_ENTRIES); sw_add is 5 bits wide and its MSB must be 0.
- STARVE_LIMIT, 8, number of consecutive cycles with sw pending and not granted before sw is forced to win the slot.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- sw_cs  in  1  sw request; held until grant
- sw_ce  in  1  with sw_cs: compare request
- sw_we  in  1  with sw_cs: write request
- sw_add  in  5  sw address
- sw_wdat  in  N_DATA_BITS  sw write/compare data
- yield  in  1  controller timeout warning
- grant  out  1  sw access performed this cycle
- sw_rdat  out  N_DATA_BITS  sw read data
- sw_match  out  1  compare hit
- sw_aindex  out  4  lowest matching index
- fn_rd  in  1  functional read
- fn_wr  in  1  functional write
- fn_addr  in  N_ADDR_BITS  functional address
- fn_wdat  in  N_DATA_BITS  functional write data
- fn_stall  out  1  functional request not serviced this cycle; hold it
- fn_rvld  out  1  functional read data valid
- fn_rdat  out  N_DATA_BITS  functional read data
- par_err  out  1  parity error pulse (macro only; tied 0 otherwise)

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: all outputs 0, starve counter 0, table contents 0, pipeline empty.

Request decode:
- sw_cs=1, sw_we=1: write.
- sw_cs=1, sw_ce=1, sw_we=0: compare.
- sw_cs=1, sw_ce=0, sw_we=0: read.
- sw_we takes precedence over sw_ce.

Arbitration (combinational per cycle):
- sw wins if sw_cs=1 and any of: no fn request, yield=1, or starve_cnt==STARVE_LIMIT-1.
- Otherwise fn wins and sw waits.
- grant=1 exactly in the cycle sw wins. fn_stall=1 in that same cycle if a fn request is present.
- grant is combinational; the controller drops sw_cs on the cycle after grant.
- The access is performed on the grant clock edge.

Starve counter:
- Increments while sw_cs=1 and grant=0.
- Clears on grant or when sw_cs=0.
- Saturates at STARVE_LIMIT-1.

Read path:
- sw read granted at cycle G: sw_rdat is registered and valid at G+1, held until the next sw read grant.
- fn read at cycle F: fn_rvld=1 and fn_rdat valid at F+1.
- Write in the same cycle to the same address: the read returns the old data (read-before-write).

Write:
- The table updates at the grant edge (sw) or the service edge (fn).
- fn_rd and fn_wr both asserted: the write executes and no read is returned.

Compare (2-stage pipeline):
- G: every entry is compared against sw_wdat and the match vector is registered.
- G+1: the lowest set index is priority-encoded and registered.
- G+2: sw_match and sw_aindex are valid, held until the next compare completes.
- No hit: sw_match=0, sw_aindex=0.
- A write landing at G+1 does not affect the in-flight result.

Out-of-range address:
- sw_add[4]=1 or sw_add>=N_ENTRIES: the access is granted, writes are dropped, reads return 0.

Reset mid-operation:
- Clears pipelines and outputs immediately.
- Table contents are cleared to 0.

Optional Feature:
- NX_IA_MEM_PARITY_EN defined:
  - Each entry stores an extra even-parity bit, computed on write.
  - On sw or fn read, parity is checked at the data-valid cycle; a mismatch pulses par_err for 1 cycle.
  - An error-inject input is not provided; the bench forces a table bit to exercise the check.
- NX_IA_MEM_PARITY_EN undefined:
  - No parity storage or check.
  - par_err is tied 0.

Test Plan:
- Idle fn; sw write addr 3 data 0xDEAD_BEEF_0000_0001, then sw read addr 3 -> grant the same cycle as sw_cs in both accesses; sw_rdat=0xDEAD_BEEF_0000_0001 one cycle after the read grant.
- Entries 2 and 9 = 0x55, sw compare 0x55 -> sw_match=1, sw_aindex=2 at G+2. Compare 0x77 -> sw_match=0, sw_aindex=0.
- fn_rd asserted continuously, sw read pending -> grant occurs exactly on the 8th pending cycle (STARVE_LIMIT=8); fn_stall=1 in that cycle only.
- fn busy, sw pending, yield=1 at pending cycle 3 -> grant in cycle 3; the fn request stalls one cycle, then fn_rvld is returned.
- sw read addr 20 -> grant issued, sw_rdat=0. sw write addr 17 -> table unchanged, confirmed by readback of all entries.
- rst_n deasserted at G+1 of a compare -> sw_match=0 and sw_aindex=0 immediately; after reset, all entries read 0. With NX_IA_MEM_PARITY_EN: force a stored bit, read -> par_err pulses for one cycle.
